// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcodes, fetch FSM states and
// default bus widths.
package cpu_pkg;

   localparam int DEF_ADDR_W = 13;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [2:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      FETCH_LO = 2'd0,
      FETCH_HI = 2'd1,
      HOLD     = 2'd2,
      HALTED   = 2'd3
   } fetch_state_t;

   function automatic logic is_hlt(input logic [2:0] op);
      return op == OP_HLT;
   endfunction

endpackage

// File: rtl/instr_buf.sv
// One assembled-instruction register {opcode, addr, pc, valid}.
// A load takes precedence over a clear so an entry can be replaced in place.
module instr_buf
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [2:0]        new_opcode,
   input  logic [ADDR_W-1:0] new_addr,
   input  logic [ADDR_W-1:0] new_pc,
   output logic              valid,
   output logic [2:0]        opcode,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid  <= 1'b0;
         opcode <= '0;
         addr   <= '0;
         pc     <= '0;
      end else if (load) begin
         valid  <= 1'b1;
         opcode <= new_opcode;
         addr   <= new_addr;
         pc     <= new_pc;
      end else if (clear) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads two ROM bytes per instruction, owns the pc.
// FETCH_SKID_EN adds a one-entry skid buffer that keeps fetching while stalled.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd,
   output logic              rom_ena,
   input  logic [DATA_W-1:0] rom_data,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [2:0]        ir_opcode,
   output logic [ADDR_W-1:0] ir_addr,
   output logic [ADDR_W-1:0] ir_pc,
   input  logic              jmp_req,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic              skip_req,
   output logic              halted
);

   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] pc, pc_next;
   logic [DATA_W-1:0] lo_byte;
   logic [2:0]        new_opcode;
   logic [ADDR_W-1:0] new_addr;
   logic              done, xfer, hlt_xfer, skip_xfer, kill, out_free;
   logic              out_load, full_after, hlt_held;
   logic [2:0]        src_opcode;
   logic [ADDR_W-1:0] src_addr, src_pc;

   // High byte carries {opcode, addr[12:8]}; low byte was latched in FETCH_LO.
   assign new_opcode = rom_data[DATA_W-1 -: 3];
   assign new_addr   = {rom_data[ADDR_W-DATA_W-1:0], lo_byte};
   assign done       = state == FETCH_HI;
   assign xfer       = ir_valid && ir_ready;
   assign hlt_xfer   = xfer && is_hlt(ir_opcode);
   assign skip_xfer  = xfer && skip_req;
   assign kill       = jmp_req || hlt_xfer || skip_xfer;
   assign out_free   = !ir_valid || xfer;

`ifdef FETCH_SKID_EN
   logic              buf_valid, buf_load;
   logic [2:0]        buf_opcode;
   logic [ADDR_W-1:0] buf_addr, buf_pc;

   assign buf_load   = done && !kill && (!out_free || buf_valid);
   assign out_load   = out_free && !kill && (buf_valid || done);
   assign src_opcode = buf_valid ? buf_opcode : new_opcode;
   assign src_addr   = buf_valid ? buf_addr : new_addr;
   assign src_pc     = buf_valid ? buf_pc : pc;
   assign full_after = !out_free || buf_valid;
   // Never fetch past an HLT that is still waiting in the skid entry.
   assign hlt_held   = buf_valid && is_hlt(buf_opcode);

   instr_buf #(.ADDR_W(ADDR_W)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (buf_load),
      .clear      (kill || out_free),
      .new_opcode (new_opcode),
      .new_addr   (new_addr),
      .new_pc     (pc),
      .valid      (buf_valid),
      .opcode     (buf_opcode),
      .addr       (buf_addr),
      .pc         (buf_pc)
   );
`else
   assign out_load   = done && !kill;
   assign src_opcode = new_opcode;
   assign src_addr   = new_addr;
   assign src_pc     = pc;
   assign full_after = 1'b1;
   assign hlt_held   = 1'b0;
`endif

   instr_buf #(.ADDR_W(ADDR_W)) u_out (
      .clk        (clk),
      .rst        (rst),
      .load       (out_load),
      .clear      (kill || xfer),
      .new_opcode (src_opcode),
      .new_addr   (src_addr),
      .new_pc     (src_pc),
      .valid      (ir_valid),
      .opcode     (ir_opcode),
      .addr       (ir_addr),
      .pc         (ir_pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH_LO;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (state == FETCH_LO) lo_byte <= rom_data;
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      if (jmp_req) begin
         state_next = FETCH_LO;
         pc_next    = jmp_target;
      end else if (hlt_xfer) begin
         state_next = HALTED;
      end else if (skip_xfer) begin
         // Restart two instructions past the one just delivered.
         state_next = FETCH_LO;
         pc_next    = ir_pc + ADDR_W'(4);
      end else begin
         case (state)
            FETCH_LO: state_next = FETCH_HI;
            FETCH_HI: begin
               pc_next    = pc + ADDR_W'(2);
               state_next = (is_hlt(new_opcode) || full_after) ? HOLD : FETCH_LO;
            end
            HOLD:     if (xfer && !hlt_held) state_next = FETCH_LO;
            default:  state_next = state;
         endcase
      end
   end

   always_comb begin
      rom_addr = pc;
      rom_rd   = 1'b0;
      if (!rst) begin
         case (state)
            FETCH_LO: rom_rd = 1'b1;
            FETCH_HI: begin
               rom_addr = pc + ADDR_W'(1);
               rom_rd   = 1'b1;
            end
            default:  rom_rd = 1'b0;
         endcase
      end
   end

   assign rom_ena = rom_rd;
   assign halted  = state == HALTED;

endmodule
